// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold values 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_adder_cell.sv
// One-bit full adder built from two half adders and a carry OR.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module bit_adder_cell (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic carry
);
    logic ab_sum;
    logic ab_carry;
    logic sc_carry;

    half_adder u_ha_ab (
        .a     (A),
        .b     (B),
        .sum   (ab_sum),
        .carry (ab_carry)
    );

    half_adder u_ha_sc (
        .a     (ab_sum),
        .b     (cin),
        .sum   (sum),
        .carry (sc_carry)
    );

    assign carry = ab_carry | sc_carry;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared full-adder cell, LSB first, one bit per clock.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               carry_reg, carry_next;
    logic               carry_out_reg, carry_out_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               cell_sum;
    logic               cell_carry;
    logic [WIDTH-1:0]   s_msb;

    bit_adder_cell u_cell (
        .A     (a_reg[0]),
        .B     (b_reg[0]),
        .cin   (carry_reg),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_out_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            sum_reg       <= sum_next;
            carry_reg     <= carry_next;
            carry_out_reg <= carry_out_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        sum_next       = sum_reg;
        carry_next     = carry_reg;
        carry_out_next = carry_out_reg;
        cnt_next       = cnt_reg;
        // Mask form of the MSB insert keeps WIDTH=1 legal (no empty slice).
        s_msb             = '0;
        s_msb[WIDTH-1]    = cell_sum;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = A;
                    b_next     = B;
                    carry_next = cin;
                    cnt_next   = '0;
                    sum_next   = '0;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                sum_next   = (sum_reg >> 1) | s_msb;
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                carry_next = cell_carry;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    carry_out_next = cell_carry;
                    state_next     = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign sum   = sum_reg;
    assign carry = carry_out_reg;

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It time-multiplexes a single 1-bit adder cell, built from two half-adder stages plus a carry OR, across WIDTH operand bits, one bit per clock.
- Operands and carry-in are captured on a start handshake.
- The block sequences the bit cell LSB-first and holds the carry between cycles.
- It reports sum and carry-out with a one-cycle done pulse.
- It sits as the sequencing wrapper around the adder datapath cells, trading area for latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range >= 1).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled at rising clk
- A      input   WIDTH  operand A; captured when start is accepted
- B      input   WIDTH  operand B; captured when start is accepted
- cin    input   1      carry-in; captured when start is accepted
- busy   output  1      high while state == RUN
- done   output  1      one-cycle pulse; result valid
- sum    output  WIDTH  result; held stable until next accepted start
- carry  output  1      carry-out of bit WIDTH-1; held like sum

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, busy=0, done=0, sum=0, carry=0, counter=0, operand shift regs=0, carry reg=0.
- States: IDLE, RUN, DONE, held in a 2-bit enum.
- IDLE:
  - start=1 -> latch A, B into shift regs, carry_reg<=cin, cnt<=0, sum<=0 -> RUN.
  - start=0 -> stay in IDLE.
- RUN, each edge:
  - bit cell computes s=a[0]^b[0]^carry_reg and c=maj(a[0],b[0],carry_reg).
  - sum shifts right with s entering the MSB.
  - a and b shift right; carry_reg<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: carry<=c -> DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 -> accepted exactly as in IDLE (back-to-back operation) -> RUN.
  - otherwise -> IDLE.
- Latency: start sampled at edge k -> busy=1 after edge k -> done=1 after edge k+WIDTH, with sum and carry valid from that same cycle.
- Throughput: one add per WIDTH+1 cycles when back-to-back.
- start while busy (RUN) is ignored; captured operands are unaffected; no error flag.
- A, B and cin may change freely after capture without affecting the result.
- sum and carry are architectural only when done=1 or in IDLE after a completed op. During RUN, sum holds partial shift contents and carry holds its previous value.
- rst_n asserted mid-RUN: immediate return to reset values; no done pulse; the op is lost.
- WIDTH=1: a single RUN cycle; DONE after edge k+1.
- Arithmetic: {carry,sum} == A + B + cin, modulo 2^(WIDTH+1) (i.e. exact).
- busy and done are never simultaneously high.

Decomposition:
- Package serial_adder_pkg:
  - state_t enum {IDLE, RUN, DONE}, logic [1:0].
  - helper function for CNT_W.
- Sub-module bit_adder_cell (A, B, cin -> sum, carry): purely combinational full adder composed of two half-adder instances plus an OR. This is the only datapath instance.
- The controller holds FSM, counter, shift registers and carry register.

Test Plan:
All cases use WIDTH=8 unless stated.
1. A=0x0F, B=0x01, cin=0, start pulse -> done after 8 cycles; sum=0x10, carry=0; busy high exactly 8 cycles.
2. A=0xFF, B=0x01, cin=0 -> sum=0x00, carry=1. Then A=0xFF, B=0xFF, cin=1 -> sum=0xFF, carry=1.
3. start held high continuously with A=0x12, B=0x34 then A=0x80, B=0x80 presented at the DONE cycle:
   - first done -> 0x46/0; next done exactly 9 cycles later -> 0x00/1.
   - start pulses during RUN do not restart the op.
4. Change A and B every cycle during RUN -> result equals the captured operands' sum.
5. Deassert rst_n at cycle 4 of RUN -> outputs go to 0 asynchronously; no done pulse. A new start after release gives a correct result.
6. WIDTH=1 instance: exhaustive over all 8 combinations of A, B and cin -> {carry,sum}=A+B+cin, with done 1 cycle after start.
